mux2_1: RTL and testbench



---
 rtl/mux2_1_pkg.sv | 9 +
 rtl/mux2_1_if.sv | 17 +
 rtl/mux2_core.sv | 15 +
 rtl/mux2_1.sv | 49 ++++
 tb/tb_mux2_1.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/mux2_1_pkg.sv
// Shared constants for the mux primitives: width limit and select encodings.
package mux_pkg;

  localparam int MUX_MAX_WIDTH = 64;

  localparam logic SEL_I0 = 1'b0;
  localparam logic SEL_I1 = 1'b1;

endpackage : mux_pkg

// File: rtl/mux2_1_if.sv
// Data bundle of a 2:1 mux: two inputs, select, one output. No handshake --
// the master drives i0/i1/j every cycle and the slave presents o unconditionally.
interface mux2_1_if
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
);

  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic             j;
  logic [WIDTH-1:0] o;

  modport master (output i0, output i1, output j, input o);
  modport slave  (input i0, input i1, input j, output o);

endinterface : mux2_1_if

// File: rtl/mux2_core.sv
// Combinational 2:1 select, bitwise across the full data width.
module mux2_core
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic             j,
  output logic [WIDTH-1:0] sel
);

  assign sel = (j == SEL_I0) ? i0 : i1;

endmodule : mux2_core

// File: rtl/mux2_1.sv
// Parameterised 2:1 mux with an optional output register (1-cycle latency,
// synchronous active-high reset to RST_VAL) or a purely combinational output.
module mux2_1
  import mux_pkg::*;
#(
  parameter int                         WIDTH   = 1,
  parameter bit                         REG_OUT = 1'b1,
  parameter logic [MUX_MAX_WIDTH-1:0]   RST_VAL = '0
) (
  input  logic     clk,
  input  logic     rst,
  mux2_1_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > MUX_MAX_WIDTH) begin : g_width_check
    $error("mux2_1: WIDTH=%0d outside 1..%0d", WIDTH, MUX_MAX_WIDTH);
  end

  logic [WIDTH-1:0] sel;

  mux2_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .i0  (bus.i0),
    .i1  (bus.i1),
    .j   (bus.j),
    .sel (sel)
  );

  if (REG_OUT) begin : g_reg
    // RST_VAL is carried at the maximum width; only the low WIDTH bits apply.
    localparam logic [WIDTH-1:0] RST_O = RST_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] o_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        o_q <= RST_O;
      end else begin
        o_q <= sel;
      end
    end

    assign bus.o = o_q;
  end else begin : g_comb
    assign bus.o = sel;
  end

endmodule : mux2_1

// File: tb/tb_mux2_1.sv
// Bench for mux2_1: three registered instances and one combinational instance,
// driven with directed and random patterns and checked against a reference model.
module tb_mux2_1;

  logic clk;
  logic rst;
  logic rst_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mux2_1_if #(.WIDTH(1)) bus1 ();
  mux2_1_if #(.WIDTH(8)) bus8 ();
  mux2_1_if #(.WIDTH(8)) bus8r ();
  mux2_1_if #(.WIDTH(1)) busc ();

  mux2_1 #(.WIDTH(1), .REG_OUT(1'b1), .RST_VAL(64'd0)) dut1 (
    .clk (clk), .rst (rst), .bus (bus1));

  mux2_1 #(.WIDTH(8), .REG_OUT(1'b1), .RST_VAL(64'd0)) dut8 (
    .clk (clk), .rst (rst), .bus (bus8));

  mux2_1 #(.WIDTH(8), .REG_OUT(1'b1), .RST_VAL(64'h5A)) dut8r (
    .clk (clk), .rst (rst), .bus (bus8r));

  mux2_1 #(.WIDTH(1), .REG_OUT(1'b0), .RST_VAL(64'd0)) dutc (
    .clk (clk), .rst (rst_c), .bus (busc));

  // scoreboard
  logic [0:0] exp1_q[$];
  logic [7:0] exp8_q[$];
  logic [7:0] exp8r_q[$];
  logic [0:0] expc_q[$];
  int n_cmp;
  int n_err;
  event comb_ev;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the output is the input indexed by the select, or the
  // reset value when reset is sampled high.
  function automatic logic [7:0] model(input logic r, input logic [7:0] rv,
                                       input logic sel, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [7:0] ins [2];
    ins[0] = a;
    ins[1] = b;
    return r ? rv : ins[sel];
  endfunction

  // One registered-stimulus cycle: 1-bit lane gets a/b, 8-bit lanes get w0/w1.
  task automatic drive(input logic r, input logic sel, input logic a, input logic b,
                       input logic [7:0] w0, input logic [7:0] w1);
    logic [7:0] e1;
    rst     = r;
    bus1.j  = sel;  bus1.i0  = a;  bus1.i1  = b;
    bus8.j  = sel;  bus8.i0  = w0; bus8.i1  = w1;
    bus8r.j = sel;  bus8r.i0 = w0; bus8r.i1 = w1;
    e1 = model(r, 8'h00, sel, {7'd0, a}, {7'd0, b});
    exp1_q.push_back(e1[0]);
    exp8_q.push_back(model(r, 8'h00, sel, w0, w1));
    exp8r_q.push_back(model(r, 8'h5A, sel, w0, w1));
    @(negedge clk);
  endtask

  // monitor for registered outputs: one result per rising edge
  always @(posedge clk) begin
    #1;
    if (exp1_q.size() > 0)  check("reg_w1",     64'(bus1.o),  64'(exp1_q.pop_front()));
    if (exp8_q.size() > 0)  check("reg_w8",     64'(bus8.o),  64'(exp8_q.pop_front()));
    if (exp8r_q.size() > 0) check("reg_w8_rv",  64'(bus8r.o), 64'(exp8r_q.pop_front()));
  end

  // monitor for the combinational output: checked within the same time step
  initial begin
    forever begin
      @(comb_ev);
      #1;
      if (expc_q.size() > 0) check("comb_w1", 64'(busc.o), 64'(expc_q.pop_front()));
    end
  end

  initial begin
    logic [7:0] e;
    n_cmp = 0;
    n_err = 0;
    rst_c = 1'b0;
    busc.j = 1'b0; busc.i0 = 1'b0; busc.i1 = 1'b0;

    // reset held for two edges with j=1, i1=1, then released
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'hA5);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'hA5);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'hA5);

    // exhaustive 1-bit truth table, random wide data alongside
    for (int k = 0; k < 8; k++) begin
      logic [2:0] c;
      c = 3'(k);
      drive(1'b0, c[2], c[1], c[0], 8'($urandom), 8'($urandom));
    end

    // reset mid-stream with j=1, i1=0xA5 running
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 8'hA5);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 8'hA5);
    for (int k = 0; k < 2; k++) drive(1'b0, 1'b1, 1'b1, 1'b0, 8'h11, 8'hA5);

    // wide data with j toggling every cycle
    for (int k = 0; k < 8; k++) drive(1'b0, k[0], 1'b0, 1'b1, 8'h3C, 8'hC3);

    // random traffic with occasional reset pulses
    for (int k = 0; k < 200; k++) begin
      drive(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom));
    end

    rst = 1'b0;
    @(posedge clk);
    #2;

    // combinational instance: 8 combinations then random, 5-unit spacing,
    // with its reset toggling to show it has no effect
    for (int k = 0; k < 40; k++) begin
      logic [2:0] c;
      c = (k < 8) ? 3'(k) : 3'($urandom);
      rst_c   = 1'($urandom);
      busc.j  = c[2];
      busc.i0 = c[1];
      busc.i1 = c[0];
      e = model(1'b0, 8'h00, c[2], {7'd0, c[1]}, {7'd0, c[0]});
      expc_q.push_back(e[0]);
      -> comb_ev;
      #5;
    end
    #5;

    if (exp1_q.size() + exp8_q.size() + exp8r_q.size() + expc_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected results left unchecked, expected 0",
               exp1_q.size() + exp8_q.size() + exp8r_q.size() + expc_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mux2_1
